// File: rtl/xphy_train_arb_if.sv
// Host register-access port of the PHY training bus arbiter.
// Request is held until ack; ack, rddata and err arrive together.
interface xphy_train_arb_if;
  logic        host_req;
  logic        host_rnw;
  logic        host_drp;
  logic [20:0] host_addr;
  logic [15:0] host_wrdata;
  logic        host_ack;
  logic [15:0] host_rddata;
  logic        host_err;

  modport master (
    output host_req, host_rnw, host_drp,
    output host_addr, host_wrdata,
    input  host_ack, host_rddata, host_err
  );

  modport slave (
    input  host_req, host_rnw, host_drp,
    input  host_addr, host_wrdata,
    output host_ack, host_rddata, host_err
  );
endinterface

// File: rtl/xphy_train_arb.sv
// Training (IPIF/DRP) bus arbiter: host bridge vs link-status poller.
// Poller, poll timer and arbitration exist only with XPHY_TRAIN_POLL_EN.
module xphy_train_arb #(
  parameter logic [20:0] C_POLL_ADDR   = 21'h030001,
  parameter logic [15:0] C_POLL_PERIOD = 16'd1000,
  parameter logic [15:0] C_ACK_TIMEOUT = 16'd256,
  parameter int          C_LINK_BIT    = 2
) (
  input  logic        clk156,
  input  logic        reset,
  input  logic        resetdone,
  xphy_train_arb_if.slave host,
  output logic        training_enable,
  output logic [20:0] training_addr,
  output logic        training_rnw,
  output logic [15:0] training_wrdata,
  output logic        training_ipif_cs,
  output logic        training_drp_cs,
  input  logic [15:0] training_rddata,
  input  logic        training_rdack,
  input  logic        training_wrack,
  output logic [15:0] poll_status,
  output logic        poll_valid,
  output logic        link_up
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t      state;
  logic [15:0] tmo_cnt;
  logic        last_host;
  logic        cur_poll;
  logic        poll_pend;
  logic        gnt_host;
  logic        gnt_poll;
  logic        ack_ok;
  logic        abort_now;
  logic        bus_done;

  always_comb begin
    gnt_host = 1'b0;
    gnt_poll = 1'b0;
    if (state == S_IDLE && resetdone) begin
      if (host.host_req && poll_pend) begin
        gnt_host = !last_host;
        gnt_poll = last_host;
      end else begin
        gnt_host = host.host_req;
        gnt_poll = poll_pend;
      end
    end
  end

  // the wrong-type ack never completes a transfer
  assign ack_ok = training_rnw ? training_rdack
                               : training_wrack;
  assign abort_now = !resetdone ||
    (!ack_ok && tmo_cnt == C_ACK_TIMEOUT - 16'd1);
  assign bus_done = (state == S_BUS) &&
    (ack_ok || abort_now);

  always_ff @(posedge clk156) begin
    if (reset) begin
      state            <= S_IDLE;
      tmo_cnt          <= '0;
      last_host        <= 1'b0;
      cur_poll         <= 1'b0;
      training_enable  <= 1'b0;
      training_addr    <= '0;
      training_rnw     <= 1'b1;
      training_wrdata  <= '0;
      training_ipif_cs <= 1'b0;
      training_drp_cs  <= 1'b0;
      host.host_ack    <= 1'b0;
      host.host_rddata <= '0;
      host.host_err    <= 1'b0;
    end else begin
      host.host_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (gnt_host || gnt_poll) begin
            state           <= S_BUS;
            tmo_cnt         <= '0;
            last_host       <= gnt_host;
            cur_poll        <= gnt_poll;
            training_enable <= 1'b1;
            if (gnt_host) begin
              training_addr    <= host.host_addr;
              training_rnw     <= host.host_rnw;
              training_wrdata  <= host.host_wrdata;
              training_ipif_cs <= !host.host_drp;
              training_drp_cs  <= host.host_drp;
            end else begin
              training_addr    <= C_POLL_ADDR;
              training_rnw     <= 1'b1;
              training_wrdata  <= '0;
              training_ipif_cs <= 1'b1;
              training_drp_cs  <= 1'b0;
            end
          end
        end
        S_BUS: begin
          if (bus_done) begin
            state            <= S_RESP;
            training_enable  <= 1'b0;
            training_addr    <= '0;
            training_rnw     <= 1'b1;
            training_wrdata  <= '0;
            training_ipif_cs <= 1'b0;
            training_drp_cs  <= 1'b0;
            if (!cur_poll) begin
              host.host_ack <= 1'b1;
              host.host_err <= abort_now;
              if (abort_now)
                host.host_rddata <= 16'hFFFF;
              else if (training_rnw)
                host.host_rddata <= training_rddata;
              else
                host.host_rddata <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef XPHY_TRAIN_POLL_EN
  logic [15:0] poll_cnt;

  // a wrap in the grant cycle re-arms the flag
  always_ff @(posedge clk156) begin
    if (reset || !resetdone) begin
      poll_cnt  <= '0;
      poll_pend <= 1'b0;
    end else if (poll_cnt == C_POLL_PERIOD - 16'd1) begin
      poll_cnt  <= '0;
      poll_pend <= 1'b1;
    end else begin
      poll_cnt <= poll_cnt + 16'd1;
      if (gnt_poll)
        poll_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      poll_status <= '0;
      poll_valid  <= 1'b0;
      link_up     <= 1'b0;
    end else begin
      poll_valid <= 1'b0;
      if (!resetdone)
        link_up <= 1'b0;
      if (bus_done && cur_poll) begin
        poll_valid <= 1'b1;
        if (abort_now) begin
          link_up <= 1'b0;
        end else begin
          poll_status <= training_rddata;
          link_up     <= training_rddata[C_LINK_BIT];
        end
      end
    end
  end
`else
  logic unused_cfg;

  assign poll_pend   = 1'b0;
  assign poll_status = '0;
  assign poll_valid  = 1'b0;
  assign link_up     = 1'b0;
  assign unused_cfg  = ^{C_POLL_PERIOD, C_LINK_BIT[3:0]};
`endif

endmodule
